// File: rtl/cog_hub_port_if.sv
// Hub bus signals between one cog's port and the hub's per-cog mux.
// master = cog side, slave = hub side.
interface cog_hub_port_if;
  logic        bus_r;
  logic        bus_e;
  logic        bus_w;
  logic [1:0]  bus_s;
  logic [15:0] bus_a;
  logic [31:0] bus_d;
  logic        bus_ack;
  logic [31:0] bus_q;
  logic        bus_c;

  modport master (
    output bus_r, bus_e, bus_w,
    output bus_s, bus_a, bus_d,
    input  bus_ack, bus_q, bus_c
  );

  modport slave (
    input  bus_r, bus_e, bus_w,
    input  bus_s, bus_a, bus_d,
    output bus_ack, bus_q, bus_c
  );
endinterface

// File: rtl/cog_hub_port.sv
// Cog-side hub bus initiator: single accesses and block cog-loads.
// Holds bus signals until this cog's ack, then captures q/c or RAM data.
module cog_hub_port #(
  parameter int LOAD_LONGS = 496
) (
  input  logic        clk_cog,
  input  logic        res,
  input  logic        ena_bus,
  input  logic        req,
  input  logic        req_w,
  input  logic [1:0]  req_s,
  input  logic [15:0] req_a,
  input  logic [31:0] req_d,
  input  logic        load,
  input  logic [13:0] load_ptr,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic        c,
  output logic        cram_w,
  output logic [8:0]  cram_a,
  output logic [31:0] cram_d,
  output logic        load_done,
  cog_hub_port_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, REQ, CAP, LREQ, LCAP
  } state_t;

  state_t      state, state_n;
  logic [13:0] ptr, ptr_n;
  logic [8:0]  cnt, cnt_n;

  logic        r_n, e_n, w_n;
  logic [1:0]  s_n;
  logic [15:0] a_n;
  logic [31:0] d_n;
  logic [31:0] q_n;
  logic        c_n;
  logic        done_n;
  logic        cram_w_n;
  logic [8:0]  cram_a_n;
  logic [31:0] cram_d_n;
  logic        load_done_n;

  logic        ack;
  logic        last;
  logic [13:0] ptr_inc;

  assign ack     = ena_bus & bus.bus_ack;
  assign last    = (cnt == 9'(LOAD_LONGS - 1));
  assign ptr_inc = ptr + 14'd1;
  assign busy    = (state != IDLE);

  // Next-state and next register values for the whole port.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    r_n         = bus.bus_r;
    e_n         = bus.bus_e;
    w_n         = bus.bus_w;
    s_n         = bus.bus_s;
    a_n         = bus.bus_a;
    d_n         = bus.bus_d;
    q_n         = q;
    c_n         = c;
    done_n      = 1'b0;
    cram_w_n    = 1'b0;
    cram_a_n    = cram_a;
    cram_d_n    = cram_d;
    load_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          ptr_n   = load_ptr;
          cnt_n   = '0;
          e_n     = 1'b1;
          r_n     = 1'b0;
          w_n     = 1'b0;
          s_n     = 2'b10;
          a_n     = {load_ptr, 2'b00};
          state_n = LREQ;
        end else if (req) begin
          e_n     = 1'b1;
          r_n     = 1'b1;
          w_n     = req_w & ~&req_s;
          s_n     = req_s;
          a_n     = req_a;
          d_n     = req_d;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          e_n     = 1'b0;
          state_n = CAP;
        end
      end
      CAP: begin
        q_n     = bus.bus_q;
        c_n     = bus.bus_c;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      LREQ: begin
        if (ack) begin
          ptr_n   = ptr_inc;
          a_n     = {ptr_inc, 2'b00};
          if (last) e_n = 1'b0;
          state_n = LCAP;
        end
      end
      LCAP: begin
        cram_w_n = 1'b1;
        cram_a_n = cnt;
        cram_d_n = bus.bus_q;
        if (last) begin
          load_done_n = 1'b1;
          state_n     = IDLE;
        end else begin
          cnt_n   = cnt + 9'd1;
          state_n = LREQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      bus.bus_r <= 1'b0;
      bus.bus_e <= 1'b0;
      bus.bus_w <= 1'b0;
      bus.bus_s <= '0;
      bus.bus_a <= '0;
      bus.bus_d <= '0;
      q         <= '0;
      c         <= 1'b0;
      done      <= 1'b0;
      cram_w    <= 1'b0;
      cram_a    <= '0;
      cram_d    <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      bus.bus_r <= r_n;
      bus.bus_e <= e_n;
      bus.bus_w <= w_n;
      bus.bus_s <= s_n;
      bus.bus_a <= a_n;
      bus.bus_d <= d_n;
      q         <= q_n;
      c         <= c_n;
      done      <= done_n;
      cram_w    <= cram_w_n;
      cram_a    <= cram_a_n;
      cram_d    <= cram_d_n;
      load_done <= load_done_n;
    end
  end

endmodule

// File: doc/cog_hub_port.md
# cog_hub_port

Cog-side initiator for the shared hub bus. Turns single hub requests from the cog (rd/wr byte/word/long and sys ops) and block cog-load requests into the hub bus signals for this cog. It holds those signals until this cog's acknowledge arrives, then captures the returned data and flags. One instance sits in each cog, between the cog's instruction/boot logic and the hub's per-cog bus mux.

## Interface
- LOAD_LONGS, 496: longs transferred by a cog-load, written to cog RAM addresses 0..LOAD_LONGS-1.
- clk_cog  in  1  cog clock, all state on rising edge.
- res  in  1  reset. Synchronous to clk_cog and active-high; it is a synchronous active-high reset.
- ena_bus  in  1  hub bus enable. Hub latches bus signals only on clk_cog edges with ena_bus=1.
- req  in  1  start a single access, sampled when idle.
- req_w  in  1  write (1) / read (0). Ignored for sys ops.
- req_s  in  2  size: 00 byte, 01 word, 10 long, 11 sys op.
- req_a  in  16  hub byte address; for sys ops, [2:0] selects the op.
- req_d  in  32  write data / sys operand.
- load  in  1  start a cog-load, sampled when idle.
- load_ptr  in  14  hub long address of first long to load.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse; single access complete, q/c valid.
- q  out  32  captured bus_q.
- c  out  1  captured bus_c.
- cram_w  out  1  one-cycle cog RAM write strobe during load.
- cram_a  out  9  cog RAM write address.
- cram_d  out  32  cog RAM write data.
- load_done  out  1  one-cycle pulse coinciding with the final cram_w.
- bus_r  out  1  1 = instruction read; 0 during cog-load, so the hub unscrambles ROM data.
- bus_e  out  1  request valid.
- bus_w  out  1  write.
- bus_s  out  2  size.
- bus_a  out  16  address.
- bus_d  out  32  data.
- bus_ack  in  1  this cog's acknowledge bit.
- bus_q  in  32  hub read data.
- bus_c  in  1  hub carry/flag.

## Operation
- States: IDLE, REQ, CAP, LREQ, LCAP. busy = (state != IDLE).
- IDLE:
  - If load=1, capture ptr = load_ptr and cnt = 0. Drive bus_e=1, bus_r=0, bus_w=0, bus_s=10, bus_a={ptr,2'b00}. Go to LREQ.
  - Else if req=1, drive bus_e=1, bus_r=1, bus_w=req_w & ~&req_s, bus_s=req_s, bus_a=req_a, bus_d=req_d. Go to REQ.
  - If load and req are both high, load wins and req is dropped.
- req/load while busy are ignored, not queued.
- REQ: on an edge with ena_bus=1 and bus_ack=1, set bus_e=0 and go to CAP. bus_ack is ignored on edges with ena_bus=0.
- CAP: next edge, q<=bus_q, c<=bus_c, done<=1, go to IDLE. q and c are captured for writes too.
- LREQ: on an ack edge (same rule as REQ), set ptr<=ptr+1 (14-bit wrap 3FFF->0000). Update bus_a to the new ptr with bus_e still 1, unless cnt==LOAD_LONGS-1, in which case bus_e<=0. Go to LCAP.
- LCAP: next edge, cram_w<=1, cram_a<=cnt, cram_d<=bus_q.
  - If cnt==LOAD_LONGS-1: load_done<=1, go to IDLE.
  - Else cnt<=cnt+1, go to LREQ.
- bus_e can stay high across the ack because this cog's slot recurs only every 8 ena_bus edges. The hub has already latched the request, and the next latch uses the updated address.
- bus_r/w/s/a/d hold their last values while bus_e=0.
- Reset values: bus_e, bus_r, bus_w, busy, done, c, cram_w, load_done = 0; bus_s, bus_a, bus_d, q, cram_a, cram_d = 0; state IDLE.
- Reset mid-operation: next edge returns to IDLE with bus_e=0. No done, load_done or cram_w is generated. A partial load is abandoned.

## Timing
- req accepted at edge T0 → bus_* valid from T0.
- Ack sampled at edge Ta → bus_q/bus_c captured at Ta+1, done high for the cycle after Ta+1.
- A new req may be accepted on the edge that ends the done cycle.
- Load throughput: one long per ack. cram_w occurs 1 clk_cog after each ack.
- done, cram_w and load_done are single-cycle registered pulses.

## Test plan
- Reset asserted for 3 clocks mid-run → every output 0, busy=0, bus_e=0 at the first edge after reset.
- rdlong req_s=10, req_a=1234h. Ack on the 3rd ena_bus edge, bus_q=DEADBEEF one clock later → bus_r=1, bus_a=1234h while waiting; q=DEADBEEF; done one cycle; bus_e=0 after ack.
- wrbyte req_w=1, req_s=00, req_d=A5h. bus_ack=1 on an edge with ena_bus=0, then on an edge with ena_bus=1 → first edge ignored, completion on second; bus_w=1, bus_d=A5h.
- lockset req_s=11, req_a=0006h, req_d=3, bus_c=1, bus_q=3 → bus_w=0, c=1, q=3, done pulse. A simultaneous load=1 is tested separately and wins over req.
- LOAD_LONGS=4, load_ptr=3FFFh, bus_q=11h/22h/33h/44h → bus_a FFFCh, 0000h, 0004h, 0008h with bus_r=0. cram_a 0..3 with data 11h..44h. load_done with 4th cram_w; bus_e=0 after 4th ack.
- res during load after 2 cram_w → bus_e=0 next edge, no further cram_w, no load_done, busy=0.
